// File: rtl/rng_share_array_seq_if.sv
// rng_share_array_seq_if: bundles the run control and result signals of rng_share_array_seq.
//   start     master->slave  begin a run; the slave honours it only when idle
//   enable    master->slave  advance permission while running (0 = stall)
//   mode      master->slave  0 = all buffers identical, 1 = per-buffer delayed
//   rngSeq    slave->master  TDIM*SDIM entries of RWID bits; entry i*SDIM+j comes from buffer i
//   rngValid  slave->master  rngSeq carries a new value this cycle
//   busy      slave->master  a run is in progress
//   done      slave->master  one-cycle pulse alongside the final valid value
interface rng_share_array_seq_if #(
    parameter int unsigned RWID = 10,
    parameter int unsigned TDIM = 1,
    parameter int unsigned SDIM = 2
);
    logic                                start;
    logic                                enable;
    logic                                mode;
    logic [TDIM*SDIM-1:0][RWID-1:0]      rngSeq;
    logic                                rngValid;
    logic                                busy;
    logic                                done;

    modport master (
        output start, enable, mode,
        input  rngSeq, rngValid, busy, done
    );

    modport slave (
        input  start, enable, mode,
        output rngSeq, rngValid, busy, done
    );
endinterface

// File: rtl/rng_share_array_seq.sv
// rng_share_array_seq: one Sobol dimension-1 generator, S(k) = bitreverse(k ^ (k >> 1)),
// fanned out to TDIM registered buffers, each buffer shared by SDIM consumers. A start
// pulse in idle launches a run of exactly 2^RWID advances; enable = 0 stalls the run. In
// mode 1, buffer i sees the sequence delayed by i*DSTEP advances (zeros until it fills).
//   clk   rising-edge clock
//   rst   synchronous active-high reset, highest priority
//   bus   slave side of rng_share_array_seq_if (start/enable/mode in, rngSeq/rngValid/busy/done out)
module rng_share_array_seq #(
    parameter int unsigned RWID  = 10,
    parameter int unsigned BDIM  = 1,
    parameter int unsigned TDIM  = (BDIM < 1) ? 1 : BDIM,
    parameter int unsigned SDIM  = 2,
    parameter int unsigned DSTEP = 1
) (
    input logic                  clk,
    input logic                  rst,
    rng_share_array_seq_if.slave bus
);

    localparam int unsigned DLEN = (TDIM - 1) * DSTEP;

    localparam logic StIdle = 1'b0;
    localparam logic StRun  = 1'b1;

    logic                           state_q, state_d;
    logic [RWID-1:0]                k_q, k_d;
    logic                           mode_q, mode_d;
    logic [TDIM-1:0][RWID-1:0]      buf_q, buf_d;
    logic                           valid_q, valid_d;
    logic                           done_q, done_d;

    logic                           accept;
    logic                           advance;
    logic                           last;
    logic [RWID-1:0]                gray;
    logic [RWID-1:0]                s_k;
    logic [TDIM-1:0][RWID-1:0]      tap;

    assign accept  = (state_q == StIdle) && bus.start;
    assign advance = (state_q == StRun) && bus.enable;
    // Final index is all ones; compared directly so the run end never depends on wrap.
    assign last    = &k_q;

    // Generator value for the current index.
    always_comb begin
        gray = k_q ^ (k_q >> 1);
        s_k  = '0;
        for (int b = 0; b < int'(RWID); b++) begin
            s_k[b] = gray[int'(RWID) - 1 - b];
        end
    end

    assign tap[0] = s_k;

    generate
        if (TDIM > 1) begin : g_dly
            // dl_q[n] holds the generator value from n+1 advances ago.
            logic [RWID-1:0] dl_q [DLEN];

            always_ff @(posedge clk) begin
                if (rst || accept) begin
                    for (int n = 0; n < int'(DLEN); n++) begin
                        dl_q[n] <= '0;
                    end
                end else if (advance) begin
                    dl_q[0] <= s_k;
                    for (int n = 1; n < int'(DLEN); n++) begin
                        dl_q[n] <= dl_q[n-1];
                    end
                end
            end

            for (genvar i = 1; i < TDIM; i++) begin : g_tap
                assign tap[i] = mode_q ? dl_q[i*DSTEP-1] : s_k;
            end
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        mode_d  = mode_q;
        buf_d   = buf_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StRun;
                    k_d     = '0;
                    mode_d  = bus.mode;
                end
            end
            StRun: begin
                if (bus.enable) begin
                    buf_d   = tap;
                    valid_d = 1'b1;
                    k_d     = k_q + RWID'(1);
                    if (last) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            k_q     <= '0;
            mode_q  <= 1'b0;
            buf_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            mode_q  <= mode_d;
            buf_q   <= buf_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // Every consumer of a buffer is wired straight to that buffer register.
    generate
        for (genvar i = 0; i < TDIM; i++) begin : g_buf
            for (genvar j = 0; j < SDIM; j++) begin : g_share
                assign bus.rngSeq[i*SDIM+j] = buf_q[i];
            end
        end
    endgenerate

    assign bus.rngValid = valid_q;
    assign bus.busy     = (state_q == StRun);
    assign bus.done     = done_q;

endmodule

// File: tb/tb_rng_share_array_seq.sv
// tb_rng_share_array_seq: directed plus randomized runs of rng_share_array_seq
// (RWID=4, TDIM=2, SDIM=2, DSTEP=2) checked against a table-driven model of the sequence.
module tb_rng_share_array_seq;

    localparam int unsigned RWID  = 4;
    localparam int unsigned BDIM  = 2;
    localparam int unsigned TDIM  = 2;
    localparam int unsigned SDIM  = 2;
    localparam int unsigned DSTEP = 2;
    localparam int          N     = 16;
    localparam int          NOUT  = TDIM * SDIM;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rng_share_array_seq_if #(.RWID(RWID), .TDIM(TDIM), .SDIM(SDIM)) bus ();

    rng_share_array_seq #(
        .RWID (RWID),
        .BDIM (BDIM),
        .SDIM (SDIM),
        .DSTEP(DSTEP)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Dimension-1 Sobol sequence for 4-bit values, in advance order.
    int unsigned seq_tab [N] = '{0, 8, 12, 4, 6, 14, 10, 2, 3, 11, 15, 7, 5, 13, 9, 1};

    function automatic logic [NOUT*RWID-1:0] expect_vec(input bit m, input int k);
        logic [NOUT*RWID-1:0] r;
        int                   d;
        int unsigned          v;
        r = '0;
        for (int o = 0; o < NOUT; o++) begin
            d = m ? (o / int'(SDIM)) * int'(DSTEP) : 0;
            v = (k >= d) ? seq_tab[k-d] : 0;
            r[o*RWID +: RWID] = v[RWID-1:0];
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag, input logic [NOUT*RWID-1:0] hold);
        logic [NOUT*RWID-1:0] obs;
        obs = bus.rngSeq;
        check({tag, "_seq"}, 64'(obs), 64'(hold));
        check({tag, "_valid"}, 64'(bus.rngValid), 64'(0));
        check({tag, "_busy"}, 64'(bus.busy), 64'(0));
        check({tag, "_done"}, 64'(bus.done), 64'(0));
    endtask

    // One run: optional directed stall, random enable, start held high during the run,
    // or a reset after a given number of valid cycles.
    task automatic do_run(input string tag, input bit m, input int stall_after,
                          input int stall_len, input bit rand_en, input bit poke,
                          input int rst_after);
        int                   k;
        int                   stall_cnt;
        int                   cyc;
        bit                   en;
        logic [NOUT*RWID-1:0] last_v;
        logic [NOUT*RWID-1:0] exp_v;
        logic [NOUT*RWID-1:0] obs;
        k         = 0;
        stall_cnt = 0;
        cyc       = 0;
        last_v    = bus.rngSeq;

        // start and enable together in idle: only start acts.
        bus.mode   = m;
        bus.start  = 1'b1;
        bus.enable = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.mode  = ~m;
        obs = bus.rngSeq;
        check({tag, "_start_busy"}, 64'(bus.busy), 64'(1));
        check({tag, "_start_noadv"}, 64'(bus.rngValid), 64'(0));
        check({tag, "_start_hold"}, 64'(obs), 64'(last_v));

        while (k < N && cyc < 200) begin
            if (rand_en) en = ($urandom_range(0, 1) == 1);
            else en = (stall_cnt == 0);
            if (stall_cnt > 0) stall_cnt--;
            bus.enable = en;
            bus.start  = poke;
            tick();
            cyc++;
            obs = bus.rngSeq;
            if (en) begin
                exp_v = expect_vec(m, k);
                k++;
                check($sformatf("%s_valid_%0d", tag, k), 64'(bus.rngValid), 64'(1));
                check($sformatf("%s_seq_%0d", tag, k), 64'(obs), 64'(exp_v));
                check($sformatf("%s_done_%0d", tag, k), 64'(bus.done), 64'(k == N));
                check($sformatf("%s_busy_%0d", tag, k), 64'(bus.busy), 64'(k != N));
                last_v = exp_v;
                if (k == stall_after) stall_cnt = stall_len;
                if (k == rst_after) begin
                    rst        = 1'b1;
                    bus.start  = 1'b1;
                    bus.enable = 1'b1;
                    tick();
                    rst       = 1'b0;
                    bus.start = 1'b0;
                    check_idle({tag, "_rst"}, '0);
                    tick();
                    tick();
                    check_idle({tag, "_rst_wait"}, '0);
                    bus.enable = 1'b0;
                    return;
                end
            end else begin
                check($sformatf("%s_stall_valid_%0d", tag, cyc), 64'(bus.rngValid), 64'(0));
                check($sformatf("%s_stall_seq_%0d", tag, cyc), 64'(obs), 64'(last_v));
                check($sformatf("%s_stall_busy_%0d", tag, cyc), 64'(bus.busy), 64'(1));
                check($sformatf("%s_stall_done_%0d", tag, cyc), 64'(bus.done), 64'(0));
            end
        end
        bus.start  = 1'b0;
        bus.enable = 1'b1;
        check({tag, "_run_len"}, 64'(k), 64'(N));
        tick();
        check_idle({tag, "_idle1"}, last_v);
        bus.enable = 1'b0;
        tick();
        check_idle({tag, "_idle2"}, last_v);
    endtask

    initial begin
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.enable = 1'b0;
        bus.mode   = 1'b0;

        // Reset held two cycles.
        tick();
        tick();
        rst = 1'b0;
        check_idle("reset", '0);
        tick();
        check_idle("reset_hold", '0);

        // Mode 0 and mode 1 full runs.
        do_run("m0", 1'b0, -1, 0, 1'b0, 1'b0, -1);
        do_run("m1", 1'b1, -1, 0, 1'b0, 1'b0, -1);

        // Stall for three cycles after the fifth valid.
        do_run("stall", 1'b0, 5, 3, 1'b0, 1'b0, -1);

        // Reset after the sixth valid, then a fresh run from the start of the sequence.
        do_run("rst_mid", 1'b1, -1, 0, 1'b0, 1'b0, 6);
        do_run("after_rst", 1'b0, -1, 0, 1'b0, 1'b0, -1);

        // start held through the run, including the last advance.
        do_run("poke", 1'b1, -1, 0, 1'b0, 1'b1, -1);

        // Randomized enable, mode and start poking.
        for (int r = 0; r < 6; r++) begin
            do_run($sformatf("rnd%0d", r), ($urandom_range(0, 1) == 1), -1, 0, 1'b1,
                   ($urandom_range(0, 1) == 1), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
